xbar_alloc: RTL and testbench
=============================

XBAR_ALLOC -- requirements
Module: xbar_alloc

Interface
REQ-001 SHALL have parameter INPUT_NUM, default 16, number of requesting inputs.
REQ-002 SHALL have parameter OUTPUT_NUM, default 16, number of crossbar outputs.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, [INPUT_NUM-1:0], input i holds a beat to send.
REQ-006 SHALL have port req_dest, input, [OUTPUT_NUM-1:0] per input (unpacked [0:INPUT_NUM-1]), one-hot destination.
REQ-007 SHALL have port req_last, input, [INPUT_NUM-1:0], beat is the final beat of its packet.
REQ-008 SHALL have port out_ready, input, [OUTPUT_NUM-1:0], output j accepts a beat this cycle.
REQ-009 SHALL have port req_grant, output, [INPUT_NUM-1:0], beat on input i transfers this cycle.
REQ-010 SHALL have port xbar_sel, output, [INPUT_NUM-1:0] per output (unpacked [0:OUTPUT_NUM-1]), one-hot or zero source select driving the crossbar.
REQ-011 SHALL have port out_valid, output, [OUTPUT_NUM-1:0], output j carries a valid beat this cycle.

Function
REQ-012 Per output j: candidates = inputs i with req_valid[i] and req_dest[i][j].
REQ-013 Per output j: state IDLE or LOCKED(owner); owner register [INPUT_NUM-1:0] one-hot.
REQ-014 IDLE: winner = first candidate at or after rr_ptr[j], wrapping INPUT_NUM-1 -> 0; no candidates -> xbar_sel[j]=0.
REQ-015 LOCKED: xbar_sel[j]=owner if owner still a candidate, else 0; other candidates ignored.
REQ-016 out_valid[j] = |xbar_sel[j]; req_grant[i] = |(xbar_sel[j][i] & out_ready[j]) over all j.
REQ-017 Combinational path request -> xbar_sel/req_grant, zero-cycle latency; no output depends on out_ready except req_grant.
REQ-018 Transfer on j = out_valid[j] & out_ready[j]; no transfer -> state, owner, rr_ptr unchanged.
REQ-019 Transfer with req_last=0: IDLE->LOCKED(winner), or LOCKED retained.
REQ-020 Transfer with req_last=1: ->IDLE; rr_ptr[j] = winner index + 1 mod INPUT_NUM.
REQ-021 Single-beat packet (req_last=1 on first beat) SHALL never enter LOCKED.
REQ-022 Malformed req_dest (zero or multi-hot) SHALL never grant more than one output to an input per cycle: input i is a candidate only on the lowest set bit of req_dest[i].
REQ-023 Each xbar_sel[j] SHALL be one-hot or zero every cycle; different outputs may select the same input only under REQ-022 exclusion, i.e. never.
REQ-024 Fairness: any input continuously requesting an IDLE output SHALL be granted within INPUT_NUM packets.

Reset
REQ-025 On reset: all outputs IDLE, owner=0, rr_ptr=0 (input 0 highest priority).
REQ-026 Reset mid-packet SHALL drop LOCKED state; next cycle behaves as fresh IDLE arbitration.
REQ-027 Outputs SHALL be 0 in the reset cycle regardless of requests.

Structure
REQ-028 One sub-module rr_lock_arb (one instance per output, generate loop) holding state, owner and rr_ptr.
REQ-029 rr_ptr width $clog2(INPUT_NUM) SHALL be a local parameter; no shared package types required; one-hot helpers SHALL be reused from the common mux_onehot/lowest-bit utilities if present.

Verification
REQ-030 Reset, inputs 0,3,5 request output 2 single-beat, out_ready=1 -> grants 0,3,5 on consecutive cycles, then 0 again.
REQ-031 Input 4 sends 3-beat packet to output 1, input 6 also requesting output 1 -> xbar_sel[1]=input 4 for all 3 beats, then input 6.
REQ-032 out_ready[1]=0 for 2 cycles mid-packet -> out_valid[1]=1, req_grant=0, owner and rr_ptr unchanged; resumes same owner.
REQ-033 Owner drops req_valid mid-packet -> xbar_sel[1]=0, other requesters blocked until owner returns and sends last.
REQ-034 Input 2 req_dest=0b0110 -> granted only on output 1; output 2 serves others.
REQ-035 Reset asserted on beat 2 of locked packet -> next cycle arbitration from input 0, no stale lock; random regression checks REQ-023 and REQ-024 every cycle.

Source files
------------

// File: rtl/xbar_alloc_pkg.sv
// ============================================================================
// Module : xbar_alloc_pkg
// Desc   : Shared state encoding and sizing helper for the crossbar allocator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package xbar_alloc_pkg;

  localparam int c_STATE_W = 1;
  localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 1'b0;
  localparam logic [c_STATE_W-1:0] c_ST_LOCKED = 1'b1;

  // Index width that stays legal for a single-input configuration.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xbar_alloc_rr_lock_arb.sv
// ============================================================================
// Module : rr_lock_arb
// Desc   : Per-output round-robin arbiter that holds its winner for a whole packet.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_lock_arb
  import xbar_alloc_pkg::*;
#(
  parameter int INPUT_NUM = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INPUT_NUM-1:0] cand,
  input  logic [INPUT_NUM-1:0] last,
  input  logic                 ready,
  output logic [INPUT_NUM-1:0] sel
);

  localparam int c_PTR_W = ptr_width(INPUT_NUM);

  logic [c_STATE_W-1:0] r_state;
  logic [c_STATE_W-1:0] w_state_nxt;
  logic [INPUT_NUM-1:0] r_owner;
  logic [INPUT_NUM-1:0] w_owner_nxt;
  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic [c_PTR_W-1:0]   w_rr_ptr_nxt;
  logic [INPUT_NUM-1:0] w_mask;
  logic [INPUT_NUM-1:0] w_hi_req;
  logic [INPUT_NUM-1:0] w_hi_pick;
  logic [INPUT_NUM-1:0] w_lo_pick;
  logic [INPUT_NUM-1:0] w_rr_pick;
  logic [c_PTR_W-1:0]   w_sel_idx;
  logic                 w_xfer;
  logic                 w_last;

  // Candidates at or above the pointer win first; otherwise wrap to the lowest.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      w_mask[i] = (i >= int'(r_rr_ptr));
    end
    w_hi_req  = cand & w_mask;
    w_hi_pick = w_hi_req & (~w_hi_req + 1'b1);
    w_lo_pick = cand & (~cand + 1'b1);
    w_rr_pick = (|w_hi_req) ? w_hi_pick : w_lo_pick;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= c_ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (sel[i]) w_sel_idx = c_PTR_W'(i);
    end
    w_xfer = (|sel) & ready;
    w_last = |(sel & last);

    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_xfer) begin
      if (w_last) begin
        w_state_nxt  = c_ST_IDLE;
        w_owner_nxt  = '0;
        w_rr_ptr_nxt = (w_sel_idx == c_PTR_W'(INPUT_NUM - 1)) ? '0 : w_sel_idx + 1'b1;
      end else begin
        w_state_nxt = c_ST_LOCKED;
        w_owner_nxt = sel;
      end
    end
  end

  // A locked output waits for its owner even if others are requesting.
  always_comb begin
    case (r_state)
      c_ST_LOCKED: sel = r_owner & cand;
      default:     sel = w_rr_pick;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/xbar_alloc.sv
// ============================================================================
// Module : xbar_alloc
// Desc   : Packet-locking crossbar allocator, one round-robin arbiter per output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xbar_alloc
  import xbar_alloc_pkg::*;
#(
  parameter int INPUT_NUM  = 16,
  parameter int OUTPUT_NUM = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INPUT_NUM-1:0]  req_valid,
  input  logic [OUTPUT_NUM-1:0] req_dest [0:INPUT_NUM-1],
  input  logic [INPUT_NUM-1:0]  req_last,
  input  logic [OUTPUT_NUM-1:0] out_ready,
  output logic [INPUT_NUM-1:0]  req_grant,
  output logic [INPUT_NUM-1:0]  xbar_sel [0:OUTPUT_NUM-1],
  output logic [OUTPUT_NUM-1:0] out_valid
);

  logic [OUTPUT_NUM-1:0] w_dest_lo [0:INPUT_NUM-1];
  logic [INPUT_NUM-1:0]  w_cand    [0:OUTPUT_NUM-1];
  logic [INPUT_NUM-1:0]  w_arb_sel [0:OUTPUT_NUM-1];

  // Only the lowest destination bit counts, so an input competes on one output at most.
  generate
    for (genvar i = 0; i < INPUT_NUM; i++) begin : g_dest
      assign w_dest_lo[i] = req_dest[i] & (~req_dest[i] + 1'b1);
    end
  endgenerate

  always_comb begin
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      w_cand[j] = '0;
      for (int i = 0; i < INPUT_NUM; i++) begin
        w_cand[j][i] = req_valid[i] & w_dest_lo[i][j];
      end
    end
  end

  generate
    for (genvar j = 0; j < OUTPUT_NUM; j++) begin : g_out
      rr_lock_arb #(
        .INPUT_NUM (INPUT_NUM)
      ) u_arb (
        .clock (clock),
        .reset (reset),
        .cand  (w_cand[j]),
        .last  (req_last),
        .ready (out_ready[j]),
        .sel   (w_arb_sel[j])
      );

      assign xbar_sel[j]  = reset ? '0 : w_arb_sel[j];
      assign out_valid[j] = |xbar_sel[j];
    end
  endgenerate

  always_comb begin
    req_grant = '0;
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      req_grant = req_grant | (xbar_sel[j] & {INPUT_NUM{out_ready[j]}});
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xbar_alloc.sv
// ============================================================================
// Module : tb_xbar_alloc
// Desc   : Directed vector table, reset corner sequence and randomised invariant run.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_xbar_alloc;

  localparam int NI = 8;
  localparam int NO = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NI-1:0] req_valid;
  logic [NO-1:0] req_dest [0:NI-1];
  logic [NI-1:0] req_last;
  logic [NO-1:0] out_ready;
  logic [NI-1:0] req_grant;
  logic [NI-1:0] xbar_sel [0:NO-1];
  logic [NO-1:0] out_valid;

  xbar_alloc #(
    .INPUT_NUM  (NI),
    .OUTPUT_NUM (NO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_last  (req_last),
    .out_ready (out_ready),
    .req_grant (req_grant),
    .xbar_sel  (xbar_sel),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  valid;
    logic [31:0] dest;
    logic [7:0]  last;
    logic [3:0]  ready;
    logic [7:0]  grant;
    logic [3:0]  ov;
    logic [31:0] sel;
  } vec_t;

  vec_t tbl [16];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(logic [7:0] v, logic [31:0] d, logic [7:0] l, logic [3:0] r,
                              logic [7:0] g, logic [3:0] o, logic [31:0] s);
    vec_t t;
    t.valid = v; t.dest = d; t.last = l; t.ready = r;
    t.grant = g; t.ov = o; t.sel = s;
    return t;
  endfunction

  task automatic drive(input logic [7:0] v, input logic [31:0] d, input logic [7:0] l,
                       input logic [3:0] r, input logic rst);
    @(negedge clock);
    reset     = rst;
    req_valid = v;
    req_last  = l;
    out_ready = r;
    for (int i = 0; i < NI; i++) req_dest[i] = d[4*i +: 4];
    #1;
  endtask

  task automatic check_outs(input string name, input logic [7:0] g, input logic [3:0] o,
                            input logic [31:0] s);
    check({name, "_grant"}, {24'h0, req_grant}, {24'h0, g});
    check({name, "_valid"}, {28'h0, out_valid}, {28'h0, o});
    check({name, "_sel"}, {xbar_sel[3], xbar_sel[2], xbar_sel[1], xbar_sel[0]}, s);
  endtask

  logic       hold     [NI];
  int         wait_cnt [NI];
  int         eff_out  [NI];
  logic [7:0] seen;
  logic [3:0] rd;

  initial begin
    // inputs 0,3,5 single-beat to output 2, then a wrap back to 0
    tbl[0]  = mk(8'h29, 32'h0040_4004, 8'hFF, 4'hF, 8'h01, 4'h4, 32'h0001_0000);
    tbl[1]  = mk(8'h29, 32'h0040_4004, 8'hFF, 4'hF, 8'h08, 4'h4, 32'h0008_0000);
    tbl[2]  = mk(8'h29, 32'h0040_4004, 8'hFF, 4'hF, 8'h20, 4'h4, 32'h0020_0000);
    tbl[3]  = mk(8'h29, 32'h0040_4004, 8'hFF, 4'hF, 8'h01, 4'h4, 32'h0001_0000);
    // input 4 three-beat packet on output 1 with a two-cycle stall, input 6 waiting
    tbl[4]  = mk(8'h50, 32'h0202_0000, 8'h40, 4'hF, 8'h10, 4'h2, 32'h0000_1000);
    tbl[5]  = mk(8'h50, 32'h0202_0000, 8'h40, 4'hD, 8'h00, 4'h2, 32'h0000_1000);
    tbl[6]  = mk(8'h50, 32'h0202_0000, 8'h40, 4'hD, 8'h00, 4'h2, 32'h0000_1000);
    tbl[7]  = mk(8'h50, 32'h0202_0000, 8'h40, 4'hF, 8'h10, 4'h2, 32'h0000_1000);
    tbl[8]  = mk(8'h50, 32'h0202_0000, 8'h50, 4'hF, 8'h10, 4'h2, 32'h0000_1000);
    tbl[9]  = mk(8'h40, 32'h0200_0000, 8'h40, 4'hF, 8'h40, 4'h2, 32'h0000_4000);
    // owner 1 disappears mid-packet; input 3 must stay blocked
    tbl[10] = mk(8'h0A, 32'h0000_2020, 8'h08, 4'hF, 8'h02, 4'h2, 32'h0000_0200);
    tbl[11] = mk(8'h08, 32'h0000_2020, 8'h08, 4'hF, 8'h00, 4'h0, 32'h0000_0000);
    tbl[12] = mk(8'h08, 32'h0000_2020, 8'h08, 4'hF, 8'h00, 4'h0, 32'h0000_0000);
    tbl[13] = mk(8'h0A, 32'h0000_2020, 8'h0A, 4'hF, 8'h02, 4'h2, 32'h0000_0200);
    tbl[14] = mk(8'h08, 32'h0000_2020, 8'h08, 4'hF, 8'h08, 4'h2, 32'h0000_0800);
    // multi-hot dest on input 2, zero dest on input 0
    tbl[15] = mk(8'h85, 32'h4000_0600, 8'hFF, 4'hF, 8'h84, 4'h6, 32'h0080_0400);

    drive(8'h29, 32'h0040_4004, 8'hFF, 4'hF, 1'b1);
    check_outs("reset_cycle", 8'h00, 4'h0, 32'h0);
    drive(8'h29, 32'h0040_4004, 8'hFF, 4'hF, 1'b1);

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].valid, tbl[k].dest, tbl[k].last, tbl[k].ready, 1'b0);
      check_outs($sformatf("vec%0d", k), tbl[k].grant, tbl[k].ov, tbl[k].sel);
    end

    // reset in the middle of a locked packet on output 3
    drive(8'h20, 32'h0080_0000, 8'hFF, 4'hF, 1'b0);
    check_outs("o3_in5", 8'h20, 4'h8, 32'h2000_0000);
    drive(8'h04, 32'h0000_0800, 8'h00, 4'hF, 1'b0);
    check_outs("o3_lock2", 8'h04, 4'h8, 32'h0400_0000);
    drive(8'h04, 32'h0000_0800, 8'h00, 4'hF, 1'b1);
    check_outs("o3_reset", 8'h00, 4'h0, 32'h0);
    drive(8'h85, 32'h8000_0808, 8'hFF, 4'hF, 1'b0);
    check_outs("o3_after_reset", 8'h01, 4'h8, 32'h0100_0000);

    drive(8'h00, 32'h0, 8'hFF, 4'hF, 1'b1);
    for (int i = 0; i < NI; i++) begin
      hold[i] = 1'b0; wait_cnt[i] = 0; eff_out[i] = -1;
    end

    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      reset     = 1'b0;
      req_last  = 8'hFF;
      out_ready = 4'($urandom_range(0, 15));
      for (int i = 0; i < NI; i++) begin
        if (!hold[i]) begin
          case ($urandom_range(0, 3))
            0: begin req_valid[i] = 1'b0; req_dest[i] = 4'h0; end
            1: begin req_valid[i] = 1'b1; req_dest[i] = 4'($urandom_range(0, 15)); end
            default: begin req_valid[i] = 1'b1; req_dest[i] = 4'h1 << $urandom_range(0, 3); end
          endcase
          eff_out[i] = -1;
          for (int j = NO - 1; j >= 0; j--) begin
            if (req_valid[i] && req_dest[i][j]) eff_out[i] = j;
          end
          hold[i]     = (eff_out[i] >= 0);
          wait_cnt[i] = 0;
        end
      end
      #1;
      seen = 8'h00;
      for (int j = 0; j < NO; j++) begin
        check("rnd_onehot", {31'h0, $onehot0(xbar_sel[j])}, 32'h1);
        check("rnd_shared_input", {24'h0, seen & xbar_sel[j]}, 32'h0);
        seen = seen | xbar_sel[j];
      end
      check("rnd_grant_subset", {24'h0, req_grant & ~req_valid}, 32'h0);
      rd = out_valid & out_ready;
      for (int i = 0; i < NI; i++) begin
        if (hold[i]) begin
          if (req_grant[i]) begin
            hold[i] = 1'b0;
          end else if (rd[eff_out[i]]) begin
            wait_cnt[i]++;
          end
          check("rnd_fairness", {31'h0, wait_cnt[i] < NI}, 32'h1);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
